seven_segment_driver: RTL and testbench

//  Drives a 4-digit, common-anode, multiplexed 7-segment display from a 16-bit value.

---
 rtl/seven_segment_driver.sv | 125 ++++++++++++
 tb/tb_seven_segment_driver.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_driver.sv
// Four-digit multiplexed common-anode 7-segment driver.
// Shows a 16-bit value as hex or decimal (mod 10000), with one selectable decimal point,
// and exports the registered digit values so it can also serve as a binary-to-BCD converter.
module seven_segment_driver #(
    parameter int unsigned REFRESH_BITS = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] din,
    input  logic        bcd,
    input  logic [1:0]  dec,
    input  logic        enable,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  ones,
    output logic [3:0]  tens,
    output logic [3:0]  hundreds,
    output logic [3:0]  thousands
);

    localparam logic [REFRESH_BITS-1:0] CntOne = {{(REFRESH_BITS-1){1'b0}}, 1'b1};

    logic [REFRESH_BITS-1:0] cnt_q;
    logic [REFRESH_BITS-1:0] cnt_d;
    logic [15:0]             dig_q;
    logic [15:0]             dig_d;
    logic [15:0]             bcd_val;
    logic [1:0]              sel;
    logic [3:0]              cur_digit;
    logic [6:0]              glyph;
    logic [3:0]              an_d;
    logic [6:0]              seg_d;
    logic                    dp_d;

    // Double-dabble over the low four BCD digits; the carry out of the thousands digit is
    // dropped each step, which leaves exactly din mod 10000.
    always_comb begin
        bcd_val = 16'd0;
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 4; j++) begin
                if (bcd_val[4*j +: 4] >= 4'd5) begin
                    bcd_val[4*j +: 4] = bcd_val[4*j +: 4] + 4'd3;
                end
            end
            bcd_val = {bcd_val[14:0], din[15-i]};
        end
    end

    // Select the digit source for the next clock.
    always_comb begin
        dig_d = bcd ? bcd_val : din;
        cnt_d = cnt_q + CntOne;
    end

    // Pick the digit currently being scanned.
    always_comb begin
        sel       = cnt_q[REFRESH_BITS-1 -: 2];
        cur_digit = 4'd0;
        unique case (sel)
            2'd0: cur_digit = dig_q[3:0];
            2'd1: cur_digit = dig_q[7:4];
            2'd2: cur_digit = dig_q[11:8];
            2'd3: cur_digit = dig_q[15:12];
        endcase
    end

    // Active-low glyph for the scanned digit, {g,f,e,d,c,b,a}.
    always_comb begin
        glyph = 7'b1111111;
        unique case (cur_digit)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            4'hF: glyph = 7'b0001110;
        endcase
    end

    // Next display values; blanking only gates the outputs, the scan keeps running.
    always_comb begin
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
        dp_d  = 1'b1;
        if (enable) begin
            an_d  = ~(4'b0001 << sel);
            seg_d = glyph;
            dp_d  = (sel == dec) ? 1'b0 : 1'b1;
        end
    end

    // Scan counter, digit register and display registers share one async reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            dig_q <= 16'd0;
            an    <= 4'b1111;
            seg   <= 7'b1111111;
            dp    <= 1'b1;
        end else begin
            cnt_q <= cnt_d;
            dig_q <= dig_d;
            an    <= an_d;
            seg   <= seg_d;
            dp    <= dp_d;
        end
    end

    assign ones      = dig_q[3:0];
    assign tens      = dig_q[7:4];
    assign hundreds  = dig_q[11:8];
    assign thousands = dig_q[15:12];

endmodule

// File: tb/tb_seven_segment_driver.sv
// Self-checking bench for seven_segment_driver with a 4-clock digit dwell.
module tb_seven_segment_driver;

    localparam int RB    = 4;
    localparam int DWELL = 1 << (RB - 2);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] din = 16'd0;
    logic        bcd = 1'b0;
    logic [1:0]  dec = 2'd0;
    logic        enable = 1'b1;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  ones;
    logic [3:0]  tens;
    logic [3:0]  hundreds;
    logic [3:0]  thousands;

    int checks = 0;
    int errors = 0;

    seven_segment_driver #(.REFRESH_BITS(RB)) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .bcd       (bcd),
        .dec       (dec),
        .enable    (enable),
        .an        (an),
        .seg       (seg),
        .dp        (dp),
        .ones      (ones),
        .tens      (tens),
        .hundreds  (hundreds),
        .thousands (thousands)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
        7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Digit index shown after a given number of edges since reset.
    function automatic int ref_k(input int cnt);
        return (cnt / DWELL) % 4;
    endfunction

    // Digit i of the value, decimal via plain arithmetic or hex nibble.
    function automatic logic [3:0] ref_digit(input logic [15:0] v, input logic b, input int i);
        int x;
        if (b) begin
            x = int'(v) % 10000;
            for (int n = 0; n < i; n++) x = x / 10;
            return 4'(x % 10);
        end
        return v[4*i +: 4];
    endfunction

    // Reference model state.
    int         m_cnt;
    logic [3:0] m_dig [4];
    logic [3:0] m_an;
    logic [6:0] m_seg;
    logic       m_dp;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_cnt <= 0;
            m_an  <= 4'b1111;
            m_seg <= 7'b1111111;
            m_dp  <= 1'b1;
            for (int i = 0; i < 4; i++) m_dig[i] <= 4'd0;
        end else begin
            m_cnt <= (m_cnt + 1) % (1 << RB);
            if (enable) begin
                m_an  <= ~(4'b0001 << ref_k(m_cnt));
                m_seg <= glyph_tab[m_dig[ref_k(m_cnt)]];
                m_dp  <= (ref_k(m_cnt) == int'(dec)) ? 1'b0 : 1'b1;
            end else begin
                m_an  <= 4'b1111;
                m_seg <= 7'b1111111;
                m_dp  <= 1'b1;
            end
            for (int i = 0; i < 4; i++) m_dig[i] <= ref_digit(din, bcd, i);
        end
    end

    logic [27:0] obs;
    logic [27:0] exp_v;
    assign obs   = {an, seg, dp, thousands, hundreds, tens, ones};
    assign exp_v = {m_an, m_seg, m_dp, m_dig[3], m_dig[2], m_dig[1], m_dig[0]};

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (an !== 4'b1111) begin
            errors++; $display("FAIL reset_an got=%b want=1111", an);
        end
        checks++;
        if (seg !== 7'b1111111) begin
            errors++; $display("FAIL reset_seg got=%b want=1111111", seg);
        end
        checks++;
        if (dp !== 1'b1) begin
            errors++; $display("FAIL reset_dp got=%b want=1", dp);
        end
        checks++;
        if ({thousands, hundreds, tens, ones} !== 16'h0000) begin
            errors++; $display("FAIL reset_digits got=%h want=0000", {thousands, hundreds, tens, ones});
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (an !== 4'b1110) begin
            errors++; $display("FAIL reset_first_an got=%b want=1110", an);
        end
    endtask

    task automatic test_hex;
        @(negedge clk);
        din = 16'hBEEF; bcd = 1'b0; enable = 1'b1; dec = 2'd0;
        repeat (2) @(negedge clk);
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL hex_model got=%h want=%h", obs, exp_v);
            end
            if (an === 4'b1110) begin
                checks++;
                if (seg !== 7'b0001110) begin
                    errors++; $display("FAIL hex_seg_d0 got=%b want=0001110", seg);
                end
            end
            if (an === 4'b0111) begin
                checks++;
                if (seg !== 7'b0000011) begin
                    errors++; $display("FAIL hex_seg_d3 got=%b want=0000011", seg);
                end
            end
        end
        checks++;
        if ({thousands, hundreds, tens, ones} !== 16'hBEEF) begin
            errors++; $display("FAIL hex_digits got=%h want=beef", {thousands, hundreds, tens, ones});
        end
    endtask

    task automatic test_bcd;
        logic [3:0] seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        bit found = 1'b0;
        @(negedge clk);
        din = 16'd1234; bcd = 1'b1; enable = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({thousands, hundreds, tens, ones} !== 16'h1234) begin
            errors++; $display("FAIL bcd_1234 got=%h want=1234", {thousands, hundreds, tens, ones});
        end
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (an === 4'b1110) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL bcd_scan_start got=%b want=1110", an);
        end else begin
            for (int j = 1; j < 4; j++) begin
                repeat (DWELL) @(negedge clk);
                checks++;
                if (an !== seq[j]) begin
                    errors++; $display("FAIL bcd_scan_step%0d got=%b want=%b", j, an, seq[j]);
                end
            end
        end
    endtask

    task automatic test_wrap;
        logic [15:0] vals [3] = '{16'd65535, 16'd9999, 16'd0};
        logic [15:0] want [3] = '{16'h5535, 16'h9999, 16'h0000};
        for (int v = 0; v < 3; v++) begin
            @(negedge clk);
            din = vals[v]; bcd = 1'b1; enable = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if ({thousands, hundreds, tens, ones} !== want[v]) begin
                errors++;
                $display("FAIL wrap_%0d got=%h want=%h", vals[v], {thousands, hundreds, tens, ones},
                         want[v]);
            end
            @(negedge clk);
            for (int c = 0; c < 16; c++) begin
                @(negedge clk);
                checks++;
                if (obs !== exp_v) begin
                    errors++; $display("FAIL wrap_model got=%h want=%h", obs, exp_v);
                end
                if (v == 2) begin
                    checks++;
                    if (seg !== 7'b1000000) begin
                        errors++; $display("FAIL wrap_zero_seg got=%b want=1000000", seg);
                    end
                end
            end
        end
    endtask

    task automatic test_dp;
        @(negedge clk);
        dec = 2'd2; enable = 1'b1; din = 16'($urandom);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c >= 1) begin
                checks++;
                if (dp !== ((an === 4'b1011) ? 1'b0 : 1'b1)) begin
                    errors++; $display("FAIL dp_digit2 got=%b an=%b", dp, an);
                end
                checks++;
                if (obs !== exp_v) begin
                    errors++; $display("FAIL dp_model got=%h want=%h", obs, exp_v);
                end
            end
        end
    endtask

    task automatic test_enable;
        logic [15:0] saved;
        @(negedge clk);
        enable = 1'b1;
        repeat (6) @(negedge clk);
        saved = {m_dig[3], m_dig[2], m_dig[1], m_dig[0]};
        enable = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
            errors++; $display("FAIL enable_off got=%b want=111111111111", {an, seg, dp});
        end
        checks++;
        if ({thousands, hundreds, tens, ones} !== saved) begin
            errors++; $display("FAIL enable_digits got=%h want=%h", {thousands, hundreds, tens, ones}, saved);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL enable_model got=%h want=%h", obs, exp_v);
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_midscan;
        repeat (6) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1}) begin
            errors++; $display("FAIL midscan_reset got=%b want=111111111111", {an, seg, dp});
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (an !== 4'b1110) begin
            errors++; $display("FAIL midscan_restart got=%b want=1110", an);
        end
    endtask

    task automatic test_random;
        bit in_reset = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL random_model cyc=%0d got=%h want=%h", c, obs, exp_v);
            end
            if (in_reset) begin
                rst = 1'b1; in_reset = 1'b0;
            end else if ($urandom_range(49) == 0) begin
                rst = 1'b0; in_reset = 1'b1;
            end
            if ($urandom_range(3) == 0) din = 16'($urandom);
            if ($urandom_range(7) == 0) bcd = 1'($urandom);
            if ($urandom_range(5) == 0) dec = 2'($urandom);
            if ($urandom_range(9) == 0) enable = 1'($urandom);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #1 rst = 1'b0;
        test_reset();
        test_hex();
        test_bcd();
        test_wrap();
        test_dp();
        test_enable();
        test_reset_midscan();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
